// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for the 5-stage RV32 pipeline: load-use and mul/div
// scoreboard stalls, branch flushes, and the mul/div completion tracker.
module hazard_scoreboard #(
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rdD,
  input  logic             RegWriteD,
  input  logic             MdOpD,
  input  logic [4:0]       rdE,
  input  logic             RegWriteE,
  input  logic             MemReadE,
  input  logic             MdStartE,
  input  logic             PCSrcE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             MdBusy,
  output logic             MdDone,
  output logic [4:0]       MdRd,
  output logic [31:0]      Pending,
  output logic [CNT_W-1:0] StallCount
);

  typedef enum logic {
    MD_IDLE,
    MD_BUSY
  } md_state_e;

  if (MD_LAT < 2 || MD_LAT > 15) begin : g_bad_md_lat
    $error("hazard_scoreboard: MD_LAT must be in 2..15");
  end

  md_state_e        state_q, state_d;
  logic [3:0]       cd_q, cd_d;
  logic [4:0]       md_rd_q, md_rd_d;
  logic [31:0]      pend_q, pend_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic lu;
  logic sb;
  logic hold;
  logic busy;

  assign busy = (state_q == MD_BUSY);

  // Hazard detection and stall/flush generation
  always_comb begin
    lu   = MemReadE & RegWriteE & (rdE != '0) & ((rdE == rs1D) | (rdE == rs2D));
    sb   = pend_q[rs1D] | pend_q[rs2D] | (RegWriteD & pend_q[rdD])
         | (MdOpD & (busy | MdStartE));
    hold = (lu | sb) & ~PCSrcE;
  end

  assign StallF     = hold;
  assign StallD     = hold;
  assign FlushD     = PCSrcE;
  assign FlushE     = hold | PCSrcE;
  assign MdBusy     = busy;
  assign MdDone     = busy & (cd_q == '0);
  assign MdRd       = md_rd_q;
  assign Pending    = pend_q;
  assign StallCount = stall_cnt_q;

  // Issue is only accepted from idle, so a completion clear and a new set
  // never land on the same edge.
  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    md_rd_d = md_rd_q;
    pend_d  = pend_q;
    unique case (state_q)
      MD_IDLE: begin
        if (MdStartE) begin
          state_d = MD_BUSY;
          md_rd_d = rdE;
          cd_d    = 4'(MD_LAT - 1);
          if (rdE != '0) pend_d[rdE] = 1'b1;
        end
      end
      MD_BUSY: begin
        if (cd_q == '0) begin
          state_d         = MD_IDLE;
          pend_d[md_rd_q] = 1'b0;
        end else begin
          cd_d = cd_q - 4'd1;
        end
      end
      default: state_d = MD_IDLE;
    endcase
    pend_d[0] = 1'b0;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hold && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= MD_IDLE;
      cd_q        <= '0;
      md_rd_q     <= '0;
      pend_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cd_q        <= cd_d;
      md_rd_q     <= md_rd_d;
      pend_q      <= pend_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  a_no_issue_while_busy: assert property (@(posedge clk) disable iff (rst)
    !(MdStartE && busy));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: stimulus queues expected outputs,
// a negedge monitor pops and compares them each cycle.
module tb_hazard_scoreboard;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1D, rs2D, rdD, rdE;
  logic        RegWriteD, MdOpD, RegWriteE, MemReadE, MdStartE, PCSrcE;

  logic        StallF, StallD, FlushD, FlushE, MdBusy, MdDone;
  logic [4:0]  MdRd;
  logic [31:0] Pending;
  logic [31:0] StallCount;

  logic        s_StallF, s_StallD, s_FlushD, s_FlushE, s_MdBusy, s_MdDone;
  logic [4:0]  s_MdRd;
  logic [31:0] s_Pending;
  logic [3:0]  s_StallCount;

  int unsigned n_chk;
  int unsigned n_fail;

  typedef struct {
    logic        stall;
    logic        fd;
    logic        fe;
    logic        busy;
    logic        done;
    logic [4:0]  mdrd;
    logic [31:0] pend;
    logic [31:0] cnt;
    logic [3:0]  scnt;
  } exp_t;

  exp_t exp_q[$];

  hazard_scoreboard #(.MD_LAT(4), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD),
    .RegWriteD(RegWriteD), .MdOpD(MdOpD), .rdE(rdE), .RegWriteE(RegWriteE),
    .MemReadE(MemReadE), .MdStartE(MdStartE), .PCSrcE(PCSrcE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .MdBusy(MdBusy), .MdDone(MdDone), .MdRd(MdRd), .Pending(Pending),
    .StallCount(StallCount)
  );

  hazard_scoreboard #(.MD_LAT(4), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD),
    .RegWriteD(RegWriteD), .MdOpD(MdOpD), .rdE(rdE), .RegWriteE(RegWriteE),
    .MemReadE(MemReadE), .MdStartE(MdStartE), .PCSrcE(PCSrcE),
    .StallF(s_StallF), .StallD(s_StallD), .FlushD(s_FlushD), .FlushE(s_FlushE),
    .MdBusy(s_MdBusy), .MdDone(s_MdDone), .MdRd(s_MdRd), .Pending(s_Pending),
    .StallCount(s_StallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one expected entry per cycle, compared at the falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("StallF", 32'(StallF), 32'(e.stall));
      chk("StallD", 32'(StallD), 32'(e.stall));
      chk("FlushD", 32'(FlushD), 32'(e.fd));
      chk("FlushE", 32'(FlushE), 32'(e.fe));
      chk("MdBusy", 32'(MdBusy), 32'(e.busy));
      chk("MdDone", 32'(MdDone), 32'(e.done));
      chk("MdRd", 32'(MdRd), 32'(e.mdrd));
      chk("Pending", Pending, e.pend);
      chk("StallCount", StallCount, e.cnt);
      chk("SatStallCount", 32'(s_StallCount), 32'(e.scnt));
    end
  end

  task automatic expect_out(input logic stall, input logic fd, input logic fe,
                            input logic busy, input logic done, input logic [4:0] mdrd,
                            input logic [31:0] pend, input int unsigned cnt);
    exp_t e;
    e.stall = stall; e.fd = fd; e.fe = fe; e.busy = busy; e.done = done;
    e.mdrd = mdrd; e.pend = pend; e.cnt = cnt;
    e.scnt = (cnt > 15) ? 4'd15 : 4'(cnt);
    exp_q.push_back(e);
  endtask

  task automatic zero_in();
    rst = 1'b0; rs1D = '0; rs2D = '0; rdD = '0; rdE = '0;
    RegWriteD = 1'b0; MdOpD = 1'b0; RegWriteE = 1'b0; MemReadE = 1'b0;
    MdStartE = 1'b0; PCSrcE = 1'b0;
  endtask

  task automatic nx();
    @(posedge clk);
    #1;
    zero_in();
  endtask

  task automatic do_reset();
    nx(); rst = 1'b1; expect_out(0, 0, 0, 0, 0, 5'd0, 32'h0, 0);
    nx();             expect_out(0, 0, 0, 0, 0, 5'd0, 32'h0, 0);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    zero_in();
    rst = 1'b1;

    do_reset();

    // Load-use on rs1, then rs2; rdE=0 and non-writing load never stall
    nx(); MemReadE = 1; RegWriteE = 1; rdE = 5'd5; rs1D = 5'd5;
    expect_out(1, 0, 1, 0, 0, 5'd0, 32'h0, 0);
    nx(); expect_out(0, 0, 0, 0, 0, 5'd0, 32'h0, 1);
    nx(); MemReadE = 1; RegWriteE = 1; rdE = 5'd0;
    expect_out(0, 0, 0, 0, 0, 5'd0, 32'h0, 1);
    nx(); MemReadE = 1; RegWriteE = 1; rdE = 5'd6; rs2D = 5'd6;
    expect_out(1, 0, 1, 0, 0, 5'd0, 32'h0, 1);
    nx(); MemReadE = 1; rdE = 5'd5; rs1D = 5'd5;
    expect_out(0, 0, 0, 0, 0, 5'd0, 32'h0, 2);

    // Taken branch overrides the load-use stall
    nx(); MemReadE = 1; RegWriteE = 1; rdE = 5'd5; rs1D = 5'd5; PCSrcE = 1;
    expect_out(0, 1, 1, 0, 0, 5'd0, 32'h0, 2);
    nx(); expect_out(0, 0, 0, 0, 0, 5'd0, 32'h0, 2);

    // Mul/div RAW on x7 held in decode
    do_reset();
    nx(); MdStartE = 1; RegWriteE = 1; rdE = 5'd7;
    expect_out(0, 0, 0, 0, 0, 5'd0, 32'h0, 0);
    nx(); rs2D = 5'd7; expect_out(1, 0, 1, 1, 0, 5'd7, 32'h80, 0);
    nx(); rs2D = 5'd7; expect_out(1, 0, 1, 1, 0, 5'd7, 32'h80, 1);
    nx(); rs2D = 5'd7; expect_out(1, 0, 1, 1, 0, 5'd7, 32'h80, 2);
    nx(); rs2D = 5'd7; expect_out(1, 0, 1, 1, 1, 5'd7, 32'h80, 3);
    nx(); rs2D = 5'd7; expect_out(0, 0, 0, 0, 0, 5'd7, 32'h0, 4);

    // Structural and WAW against an outstanding mul/div to x3
    nx(); MdStartE = 1; RegWriteE = 1; rdE = 5'd3;
    expect_out(0, 0, 0, 0, 0, 5'd7, 32'h0, 4);
    nx(); MdOpD = 1; expect_out(1, 0, 1, 1, 0, 5'd3, 32'h8, 4);
    nx(); RegWriteD = 1; rdD = 5'd3; expect_out(1, 0, 1, 1, 0, 5'd3, 32'h8, 5);
    nx(); RegWriteD = 1; rdD = 5'd8; expect_out(0, 0, 0, 1, 0, 5'd3, 32'h8, 6);
    nx(); expect_out(0, 0, 0, 1, 1, 5'd3, 32'h8, 6);
    nx(); expect_out(0, 0, 0, 0, 0, 5'd3, 32'h0, 6);

    // Mul/div issuing in EX blocks a decode mul/div; x0 destination never pends
    nx(); MdStartE = 1; RegWriteE = 1; rdE = 5'd0; MdOpD = 1;
    expect_out(1, 0, 1, 0, 0, 5'd3, 32'h0, 6);
    nx(); expect_out(0, 0, 0, 1, 0, 5'd0, 32'h0, 7);
    nx(); expect_out(0, 0, 0, 1, 0, 5'd0, 32'h0, 7);
    nx(); expect_out(0, 0, 0, 1, 0, 5'd0, 32'h0, 7);
    nx(); expect_out(0, 0, 0, 1, 1, 5'd0, 32'h0, 7);
    nx(); expect_out(0, 0, 0, 0, 0, 5'd0, 32'h0, 7);

    // Reset two edges after issue to x9: immediate clear, no late MdDone
    nx(); MdStartE = 1; RegWriteE = 1; rdE = 5'd9;
    expect_out(0, 0, 0, 0, 0, 5'd0, 32'h0, 7);
    nx(); expect_out(0, 0, 0, 1, 0, 5'd9, 32'h200, 7);
    nx(); rst = 1; expect_out(0, 0, 0, 0, 0, 5'd0, 32'h0, 0);
    for (int i = 0; i < 6; i++) begin
      nx(); expect_out(0, 0, 0, 0, 0, 5'd0, 32'h0, 0);
    end

    // Continuous load-use stall for 20 cycles; 4-bit counter saturates at 15
    do_reset();
    for (int i = 0; i < 20; i++) begin
      nx(); MemReadE = 1; RegWriteE = 1; rdE = 5'd4; rs1D = 5'd4;
      expect_out(1, 0, 1, 0, 0, 5'd0, 32'h0, i);
    end
    nx(); expect_out(0, 0, 0, 0, 0, 5'd0, 32'h0, 20);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    chk("QueueDrained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL Timeout: simulation did not finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer-side companion to the execute-stage forwarding logic in the 5-stage RV32 pipeline.
- Tracks in-flight register writes that forwarding cannot cover: the load in EX, and the single outstanding multi-cycle mul/div result.
- Generates StallF/StallD/FlushD/FlushE and the mul/div writeback-request pulse.
- Sits beside the pipeline registers; consumes decode/execute fields and branch resolution.

Parameters:
- MD_LAT, 4, mul/div latency in cycles from issue in EX to MdDone pulse (legal range 2..15).
- CNT_W, 32, width of the saturating stall-cycle performance counter.

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  asynchronous active-high reset.
- rs1D  input  5  decode source register 1.
- rs2D  input  5  decode source register 2.
- rdD  input  5  decode destination register.
- RegWriteD  input  1  decode instruction writes rdD.
- MdOpD  input  1  decode instruction is mul/div.
- rdE  input  5  execute destination register.
- RegWriteE  input  1  execute instruction writes rdE.
- MemReadE  input  1  execute instruction is a load.
- MdStartE  input  1  mul/div issuing in EX this cycle (rdE is its destination).
- PCSrcE  input  1  taken branch/jump resolved in EX.
- StallF  output  1  hold PC.
- StallD  output  1  hold IF/ID register.
- FlushD  output  1  clear IF/ID register.
- FlushE  output  1  clear ID/EX register.
- MdBusy  output  1  mul/div result outstanding.
- MdDone  output  1  one-cycle pulse: mul/div result ready for writeback.
- MdRd  output  5  destination of outstanding/completing mul/div.
- Pending  output  32  per-register pending-write vector; bit 0 is always 0.
- StallCount  output  CNT_W  saturating count of cycles with StallD=1.

Behaviour:
- Reset (async): Pending=0, MdBusy=0, MdDone=0, MdRd=0, internal countdown=0, StallCount=0. Stall/flush outputs are combinational and evaluate to 0 once the state is cleared and all inputs are 0.
- Load-use hazard lu: MemReadE & RegWriteE & rdE!=0 & (rdE==rs1D | rdE==rs2D).
- Scoreboard hazard sb, any of:
  - Pending[rs1D] or Pending[rs2D] (RAW).
  - RegWriteD & Pending[rdD] (WAW).
  - MdOpD & (MdBusy | MdStartE) (structural).
- Stall: StallF=StallD=(lu|sb) & ~PCSrcE.
- FlushE=((lu|sb) & ~PCSrcE) | PCSrcE, so a bubble is inserted while D holds.
- FlushD=PCSrcE. A taken branch overrides stalls: the younger instructions are discarded, so no stall is applied.
- x0 is never pending and never causes a hazard. rs fields are compared even if the instruction does not use them; conservative stalls are acceptable.
- Mul/div issue: on a clk edge with MdStartE=1 and MdBusy=0:
  - MdBusy<=1, MdRd<=rdE, countdown<=MD_LAT-1.
  - Pending[rdE]<=1 if rdE!=0.
  - MdStartE while MdBusy=1 is illegal (prevented by the structural stall); assertion-checked and ignored.
- Countdown: while MdBusy, decrement each cycle. When countdown==0 and MdBusy:
  - MdDone=1 for exactly that cycle (combinational from state).
  - On that edge: MdBusy<=0, Pending[MdRd]<=0.
  - MdRd holds its value until the next issue.
- Total timing: MdDone asserts MD_LAT cycles after the MdStartE edge.
- Same-edge clear and new issue cannot collide, because MdBusy gates issue. If a clear and a set target the same register on one edge, the set wins.
- Loads are not entered in Pending; they are covered by lu only (1-cycle bubble, then the forwarding path from W).
- StallCount increments on each edge where StallD=1 and saturates at all-ones (no wrap).
- Reset mid-operation: asserting rst while MdBusy immediately clears Pending, MdBusy and MdDone. No MdDone pulse is produced afterwards.

Test Plan:
- Load-use: MemReadE=1, RegWriteE=1, rdE=5, rs1D=5 -> StallF=StallD=FlushE=1, FlushD=0 for one cycle. With rdE=0 instead -> all outputs 0.
- Mul/div RAW: MdStartE=1, rdE=7, MD_LAT=4, then rs2D=7 held in D:
  - Pending[7]=1 and StallD=1 for 4 cycles.
  - MdDone=1 with MdRd=7 on the 4th cycle.
  - Pending[7]=0 and StallD=0 on the next cycle.
  - StallCount advances by 4.
- Structural and WAW: while MdBusy=1, MdOpD=1 -> StallD=1. RegWriteD=1 with rdD=MdRd and no source match -> StallD=1. rdD=8 with no match -> StallD=0.
- Branch priority: lu condition true and PCSrcE=1 in the same cycle -> FlushD=FlushE=1, StallF=StallD=0.
- Reset mid-op: rst asserted 2 cycles after issue to rd=9 -> Pending=0 and MdBusy=0 immediately; no MdDone pulse after rst deasserts.
- Saturation: CNT_W=4, continuous stall for 20 cycles -> StallCount stops at 15.
